// File: rtl/thread_pkg.sv
// Shared thread/register-file types for the writeback controller.
// Holds widths, the buffered writeback request and the arbitration select code.
package thread_pkg;
  localparam int NUM_TRD = 8;
  localparam int TRD_W   = 3;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [TRD_W-1:0]  trd;
    logic [REG_W-1:0]  rgs;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_IDLE  = 2'd0,
    SEL_ALU   = 2'd1,
    SEL_SPAWN = 2'd2,
    SEL_FIFO  = 2'd3
  } wb_sel_e;

  // r0/r1 are hard-wired and thread ids beyond the thread count do not exist.
  function automatic logic wr_target_ok(input logic [TRD_W-1:0] trd,
                                        input logic [REG_W-1:0] rgs,
                                        input int               num_trd);
    return (rgs > 5'd1) && (int'(trd) < num_trd);
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of load-return writebacks with a per-entry valid bit.
// A spawn invalidates every buffered entry (and the one being pushed) of that thread.
module wb_fifo
  import thread_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  input  logic             inv_en,
  input  logic [TRD_W-1:0] inv_trd,
  output wb_req_t          head_req,
  output logic             head_vld,
  output logic [CNT_W-1:0] cnt
);
  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for storage, valid bits, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (inv_en && (mem_q[i].trd == inv_trd)) begin
        vld_d[i] = 1'b0;
      end else begin
        vld_d[i] = vld_q[i];
      end
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_req;
      vld_d[wr_ptr_q] = !(inv_en && (push_req.trd == inv_trd));
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_req = mem_q[rd_ptr_q];
  assign head_vld = vld_q[rd_ptr_q];
  assign cnt      = cnt_q;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback arbiter: ALU beats spawn beats buffered load returns.
// All register-file port outputs are registered one cycle after selection.
module regfile_wb_ctrl
  import thread_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_TRD    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_vld,
  input  logic [2:0]  alu_trd,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        mem_vld,
  input  logic [2:0]  mem_trd,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_rdy,
  input  logic        spawn_vld,
  input  logic [2:0]  spawn_trd,
  input  logic [31:0] spawn_arg,
  output logic        spawn_rdy,
  output logic        wr_en,
  output logic [2:0]  wr_trd,
  output logic [4:0]  reg_wr,
  output logic [31:0] wr_data,
  output logic        init,
  output logic [2:0]  new_trd,
  output logic [31:0] init_data,
  output logic [2:0]  fifo_cnt,
  output logic        drop_err
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0] cnt_s;
  wb_req_t          head_s;
  logic             head_vld_s;
  wb_sel_e          sel_s;
  logic             push_s, pop_s, inv_s;

  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_trd_q, wr_trd_d;
  logic [4:0]  reg_wr_q, reg_wr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        init_q, init_d;
  logic [2:0]  new_trd_q, new_trd_d;
  logic [31:0] init_data_q, init_data_d;
  logic        drop_err_q, drop_err_d;

  assign mem_rdy   = !rst && (cnt_s < CNT_W'(FIFO_DEPTH));
  assign spawn_rdy = !rst && !alu_vld;

  // One winner per cycle; nothing is consumed while in reset.
  always_comb begin
    sel_s = SEL_IDLE;
    if (rst) begin
      sel_s = SEL_IDLE;
    end else if (alu_vld) begin
      sel_s = SEL_ALU;
    end else if (spawn_vld) begin
      sel_s = SEL_SPAWN;
    end else if (cnt_s != CNT_W'(0)) begin
      sel_s = SEL_FIFO;
    end else begin
      sel_s = SEL_IDLE;
    end
  end

  assign push_s = mem_vld && mem_rdy;
  assign pop_s  = (sel_s == SEL_FIFO);
  assign inv_s  = (sel_s == SEL_SPAWN);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_req ('{trd: mem_trd, rgs: mem_reg, data: mem_data}),
    .pop      (pop_s),
    .inv_en   (inv_s),
    .inv_trd  (spawn_trd),
    .head_req (head_s),
    .head_vld (head_vld_s),
    .cnt      (cnt_s)
  );

  // Data outputs only change on a real write or init; strobes default low.
  always_comb begin
    wr_en_d     = 1'b0;
    init_d      = 1'b0;
    drop_err_d  = 1'b0;
    wr_trd_d    = wr_trd_q;
    reg_wr_d    = reg_wr_q;
    wr_data_d   = wr_data_q;
    new_trd_d   = new_trd_q;
    init_data_d = init_data_q;
    case (sel_s)
      SEL_ALU: begin
        if (wr_target_ok(alu_trd, alu_reg, NUM_TRD)) begin
          wr_en_d   = 1'b1;
          wr_trd_d  = alu_trd;
          reg_wr_d  = alu_reg;
          wr_data_d = alu_data;
        end else begin
          drop_err_d = 1'b1;
        end
      end
      SEL_SPAWN: begin
        init_d      = 1'b1;
        new_trd_d   = spawn_trd;
        init_data_d = spawn_arg;
      end
      SEL_FIFO: begin
        // A stale (invalidated) head just retires its slot silently.
        if (!head_vld_s) begin
          drop_err_d = 1'b0;
        end else if (wr_target_ok(head_s.trd, head_s.rgs, NUM_TRD)) begin
          wr_en_d   = 1'b1;
          wr_trd_d  = head_s.trd;
          reg_wr_d  = head_s.rgs;
          wr_data_d = head_s.data;
        end else begin
          drop_err_d = 1'b1;
        end
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      wr_trd_q    <= 3'd0;
      reg_wr_q    <= 5'd0;
      wr_data_q   <= 32'd0;
      init_q      <= 1'b0;
      new_trd_q   <= 3'd0;
      init_data_q <= 32'd0;
      drop_err_q  <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_trd_q    <= wr_trd_d;
      reg_wr_q    <= reg_wr_d;
      wr_data_q   <= wr_data_d;
      init_q      <= init_d;
      new_trd_q   <= new_trd_d;
      init_data_q <= init_data_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_trd    = wr_trd_q;
  assign reg_wr    = reg_wr_q;
  assign wr_data   = wr_data_q;
  assign init      = init_q;
  assign new_trd   = new_trd_q;
  assign init_data = init_data_q;
  assign drop_err  = drop_err_q;
  assign fifo_cnt  = 3'(cnt_s);
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized + directed bench for regfile_wb_ctrl; a queue-based reference model
// predicts each register-file event and its cycle, a negedge monitor checks them.
module tb_regfile_wb_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_vld = 1'b0, mem_vld = 1'b0, spawn_vld = 1'b0;
  logic [2:0]  alu_trd = 3'd0, mem_trd = 3'd0, spawn_trd = 3'd0;
  logic [4:0]  alu_reg = 5'd0, mem_reg = 5'd0;
  logic [31:0] alu_data = 32'd0, mem_data = 32'd0, spawn_arg = 32'd0;
  logic        mem_rdy, spawn_rdy, wr_en, init, drop_err;
  logic [2:0]  wr_trd, new_trd, fifo_cnt;
  logic [4:0]  reg_wr;
  logic [31:0] wr_data, init_data;

  regfile_wb_ctrl #(.FIFO_DEPTH(DEPTH), .NUM_TRD(8)) dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_trd(alu_trd), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_vld(mem_vld), .mem_trd(mem_trd), .mem_reg(mem_reg), .mem_data(mem_data),
    .mem_rdy(mem_rdy),
    .spawn_vld(spawn_vld), .spawn_trd(spawn_trd), .spawn_arg(spawn_arg),
    .spawn_rdy(spawn_rdy),
    .wr_en(wr_en), .wr_trd(wr_trd), .reg_wr(reg_wr), .wr_data(wr_data),
    .init(init), .new_trd(new_trd), .init_data(init_data),
    .fifo_cnt(fifo_cnt), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = register write, 1 = thread init, 2 = illegal-target drop
  typedef struct {
    int          kind;
    logic [2:0]  trd;
    logic [4:0]  rg;
    logic [31:0] data;
    int          due;
  } exp_t;
  typedef struct {
    logic [2:0]  trd;
    logic [4:0]  rg;
    logic [31:0] data;
    bit          v;
  } ment_t;

  exp_t  exp_q[$];
  ment_t mq[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic expect_wr(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.kind = (r > 5'd1) ? 0 : 2;
    e.trd = t; e.rg = r; e.data = d; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs, predict the outcome, advance past the edge.
  task automatic step(input bit r,
                      input bit av, input logic [2:0] at, input logic [4:0] ar, input logic [31:0] ad,
                      input bit mv, input logic [2:0] mt, input logic [4:0] mr, input logic [31:0] md,
                      input bit sv, input logic [2:0] st, input logic [31:0] sa,
                      output bit m_acc, output bit s_acc);
    bit    mrdy;
    ment_t h;
    exp_t  e;
    chk("fifo_cnt", fifo_cnt, mq.size());
    rst = r;
    alu_vld = av; alu_trd = at; alu_reg = ar; alu_data = ad;
    mem_vld = mv; mem_trd = mt; mem_reg = mr; mem_data = md;
    spawn_vld = sv; spawn_trd = st; spawn_arg = sa;
    #1;
    m_acc = 1'b0;
    s_acc = 1'b0;
    if (r) begin
      chk("mem_rdy_in_rst", mem_rdy, 0);
      chk("spawn_rdy_in_rst", spawn_rdy, 0);
      mq.delete();
    end else begin
      mrdy = (mq.size() < DEPTH);
      chk("mem_rdy", mem_rdy, mrdy);
      chk("spawn_rdy", spawn_rdy, !av);
      if (av) begin
        expect_wr(at, ar, ad);
      end else if (sv) begin
        s_acc = 1'b1;
        e.kind = 1; e.trd = st; e.rg = 5'd0; e.data = sa; e.due = cyc + 1;
        exp_q.push_back(e);
        foreach (mq[i]) if (mq[i].trd == st) mq[i].v = 1'b0;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        if (h.v) expect_wr(h.trd, h.rg, h.data);
      end
      if (mv && mrdy) begin
        m_acc = 1'b1;
        h.trd = mt; h.rg = mr; h.data = md; h.v = !(s_acc && (mt == st));
        mq.push_back(h);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit ma, sa;
    for (int i = 0; i < n; i++)
      step(0, 0, 3'd0, 5'd0, 32'd0, 0, 3'd0, 5'd0, 32'd0, 0, 3'd0, 32'd0, ma, sa);
  endtask

  task automatic chk_zero_outputs();
    chk("rst_wr_en", wr_en, 0);      chk("rst_init", init, 0);
    chk("rst_drop_err", drop_err, 0); chk("rst_wr_trd", wr_trd, 0);
    chk("rst_reg_wr", reg_wr, 0);    chk("rst_wr_data", wr_data, 0);
    chk("rst_new_trd", new_trd, 0);  chk("rst_init_data", init_data, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
  endtask

  // Monitor: every strobe must match the oldest prediction, in its predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    int   gk;
    bit   ok;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL missing_event: kind %0d trd %0d reg %0d data 0x%0h expected at cycle %0d, not seen by %0d",
               exp_q[0].kind, exp_q[0].trd, exp_q[0].rg, exp_q[0].data, exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    if (wr_en || init || drop_err) begin
      gk = wr_en ? 0 : (init ? 1 : 2);
      n_cmp++;
      if (wr_en && init) begin
        n_err++;
        $display("FAIL wr_init_overlap: wr_en=1 init=1 at cycle %0d, expected never both", cyc);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: kind %0d wr_trd %0d reg_wr %0d wr_data 0x%0h at cycle %0d, expected none",
                 gk, wr_trd, reg_wr, wr_data, cyc);
      end else begin
        e  = exp_q.pop_front();
        ok = (e.kind == gk) && (e.due == cyc);
        if (ok && gk == 0) ok = (wr_trd == e.trd) && (reg_wr == e.rg) && (wr_data == e.data);
        if (ok && gk == 1) ok = (new_trd == e.trd) && (init_data == e.data);
        if (!ok) begin
          n_err++;
          $display("FAIL event: got kind %0d trd %0d/%0d reg %0d data 0x%0h/0x%0h cycle %0d; expected kind %0d trd %0d reg %0d data 0x%0h cycle %0d",
                   gk, wr_trd, new_trd, reg_wr, wr_data, init_data, cyc, e.kind, e.trd, e.rg, e.data, e.due);
        end
      end
    end
  end

  initial begin
    bit ma, sa;
    int k;
    repeat (2) @(posedge clk);
    #1;
    step(1, 1, 3'd1, 5'd3, 32'h1, 1, 3'd1, 5'd3, 32'h2, 1, 3'd1, 32'h3, ma, sa);
    chk_zero_outputs();

    // Basic ALU write
    step(0, 1, 3'd2, 5'd5, 32'hDEAD_BEEF, 0, 3'd0, 5'd0, 32'd0, 0, 3'd0, 32'd0, ma, sa);
    chk("alu_wr_en", wr_en, 1);
    chk("alu_wr_trd", wr_trd, 2);
    chk("alu_reg_wr", reg_wr, 5);
    chk("alu_wr_data", wr_data, 32'hDEAD_BEEF);
    idle(2);

    // Fill the buffer while the ALU hogs the port, then release it
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      step(0, c < 6, 3'd1, 5'd20, 32'hA000 + c, 1, 3'd5, 5'(10 + k), 32'h100 + k,
           0, 3'd0, 32'd0, ma, sa);
      if (ma) k++;
      if (c == 5) begin
        chk("full_cnt", fifo_cnt, 4);
        chk("full_mem_rdy", mem_rdy, 0);
      end
    end
    chk("five_accepted", k, 5);
    idle(7);

    // Spawn invalidates the stale load of its thread
    step(0, 1, 3'd0, 5'd2, 32'h11, 1, 3'd3, 5'd7, 32'h77, 0, 3'd0, 32'd0, ma, sa);
    step(0, 1, 3'd0, 5'd2, 32'h22, 1, 3'd4, 5'd8, 32'h88, 0, 3'd0, 32'd0, ma, sa);
    step(0, 0, 3'd0, 5'd0, 32'd0, 0, 3'd0, 5'd0, 32'd0, 1, 3'd3, 32'h1234, ma, sa);
    chk("spawn_init", init, 1);
    chk("spawn_new_trd", new_trd, 3);
    chk("spawn_init_data", init_data, 32'h1234);
    idle(4);

    // ALU and spawn together: ALU first, spawn retried next cycle
    step(0, 1, 3'd1, 5'd9, 32'h99, 0, 3'd0, 5'd0, 32'd0, 1, 3'd6, 32'h5150, ma, sa);
    chk("collide_spawn_acc", sa, 0);
    step(0, 0, 3'd0, 5'd0, 32'd0, 0, 3'd0, 5'd0, 32'd0, 1, 3'd6, 32'h5150, ma, sa);
    idle(2);

    // Writes to r0/r1 are dropped with an error pulse
    step(0, 1, 3'd2, 5'd1, 32'hBAD, 0, 3'd0, 5'd0, 32'd0, 0, 3'd0, 32'd0, ma, sa);
    chk("drop_err_pulse", drop_err, 1);
    chk("drop_wr_en", wr_en, 0);
    idle(1);
    chk("drop_err_clear", drop_err, 0);

    // Reset with three buffered entries discards them
    for (int i = 0; i < 3; i++)
      step(0, 1, 3'd0, 5'd4, 32'h40 + i, 1, 3'd2, 5'd12, 32'h50 + i, 0, 3'd0, 32'd0, ma, sa);
    chk("pre_rst_cnt", fifo_cnt, 3);
    step(1, 1, 3'd1, 5'd6, 32'h6, 1, 3'd1, 5'd6, 32'h7, 1, 3'd1, 32'h8, ma, sa);
    chk_zero_outputs();
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 30, 3'($urandom), 5'($urandom), $urandom,
           $urandom_range(0, 99) < 55, 3'($urandom), 5'($urandom), $urandom,
           $urandom_range(0, 99) < 15, 3'($urandom), $urandom, ma, sa);
    end
    idle(8);
    chk("events_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning memory-return buffer entries (power of two, >=2).
REQ-002 SHALL have parameter NUM_TRD, default 8, meaning hardware thread count (thread id 3 bits).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 alu_vld/alu_trd/alu_reg/alu_data  in  1/3/5/32  non-stallable ALU writeback request.
REQ-007 mem_vld/mem_trd/mem_reg/mem_data  in  1/3/5/32  load-return request; mem_rdy  out  1  accept.
REQ-008 spawn_vld/spawn_trd/spawn_arg  in  1/3/32  thread-init request; spawn_rdy  out  1  accept.
REQ-009 wr_en/wr_trd/reg_wr/wr_data  out  1/3/5/32  register-file write port.
REQ-010 init/new_trd/init_data  out  1/3/32  register-file thread-init port.
REQ-011 fifo_cnt  out  3  buffered entries (valid + invalidated); drop_err  out  1  illegal-target pulse.

Function
REQ-012 Handshakes: transfer on X_vld & X_rdy same cycle; alu has no ready, always consumed.
REQ-013 mem_rdy = !rst & (fifo_cnt < FIFO_DEPTH); accepted mem requests SHALL enqueue, never bypass.
REQ-014 spawn_rdy = !rst & !alu_vld.
REQ-015 Per-cycle selection, exactly one: alu_vld -> ALU; else spawn_vld -> spawn; else FIFO head if cnt>0; else idle.
REQ-016 All outputs on ports REQ-009/010 registered: selection in cycle N visible in cycle N+1, asserted one cycle.
REQ-017 init and wr_en SHALL never be high in the same cycle.
REQ-018 Write with reg field 0 or 1 SHALL be consumed, wr_en stays 0, drop_err pulses one cycle (N+1).
REQ-019 Spawn accept: init=1, new_trd=spawn_trd, init_data=spawn_arg next cycle.
REQ-020 Spawn accept SHALL, same edge, invalidate every FIFO entry with trd==spawn_trd (stale loads).
REQ-021 Invalidated head SHALL pop in its selection slot with wr_en=0, drop_err=0, one entry per cycle.
REQ-022 FIFO order preserved; push and pop in same cycle SHALL leave cnt unchanged.
REQ-023 Enqueue into empty FIFO at cycle N: earliest pop N+1, wr_en N+2.
REQ-024 Entry being enqueued in the spawn-accept cycle with matching trd SHALL also be marked invalid.
REQ-025 Head pointer wraps modulo FIFO_DEPTH; full state blocks mem only, never ALU or spawn.
REQ-026 Idle cycle: wr_en=0, init=0; data outputs hold last value.

Reset
REQ-027 rst high at an edge: FIFO emptied (cnt=0), pointers 0, all outputs 0, pending entries discarded.
REQ-028 During rst mem_rdy=0 and spawn_rdy=0; requests presented then are not consumed.
REQ-029 First legal selection is the first edge with rst low; outputs valid the following cycle.

Structure
REQ-030 Shared package thread_pkg SHALL hold NUM_TRD, TRD_W=3, REG_W=5, DATA_W=32 and struct wb_req_t {trd, rgs, data}.
REQ-031 Sub-module wb_fifo (circular buffer of wb_req_t plus per-entry valid bit, invalidate-by-trd port) SHALL hold the buffer; arbitration stays in regfile_wb_ctrl.

Verification
REQ-032 ALU alu_trd=2,reg=5,data=0xDEAD_BEEF at cycle 0 -> cycle 1 wr_en=1,wr_trd=2,reg_wr=5,wr_data=0xDEAD_BEEF.
REQ-033 Five mem requests back-to-back with ALU busy -> mem_rdy low after 4th, fifo_cnt=4; ALU released -> 4 writes in order, 5th accepted after first pop.
REQ-034 FIFO holds trd3 r7, trd4 r8; spawn trd3 arg 0x1234 -> init=1,new_trd=3,init_data=0x1234; then one empty slot, then trd4 r8 written; trd3 r7 never written.
REQ-035 alu_vld and spawn_vld same cycle -> spawn_rdy=0, ALU write first, init the following cycle.
REQ-036 ALU write to reg 1 -> wr_en=0, drop_err=1 for one cycle.
REQ-037 rst asserted with fifo_cnt=3 -> next cycle cnt=0, all outputs 0, no write issued after release.
